// File: rtl/systolic_seq_ctrl_if.sv
// Command/strobe bundle between the layer controller, the systolic sequencer and
// the PE grid with its operand buffers.
// master: the side that issues start/cfg_k/stall and consumes the strobes.
// slave : the sequencer itself.
interface systolic_seq_ctrl_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 16
);
    logic            start;
    logic [K_W-1:0]  cfg_k;
    logic            stall;
    logic            busy;
    logic            done;
    logic            array_enable;
    logic            feed_rd_en;
    logic [K_W-1:0]  feed_addr;
    logic [ROWS-1:0] row_data_valid;
    logic [COLS-1:0] col_weight_valid;
    logic            result_capture;
    logic [31:0]     perf_busy_cycles;
    logic [31:0]     perf_stall_cycles;

    modport master (
        output start, cfg_k, stall,
        input  busy, done, array_enable, feed_rd_en, feed_addr,
               row_data_valid, col_weight_valid, result_capture,
               perf_busy_cycles, perf_stall_cycles
    );

    modport slave (
        input  start, cfg_k, stall,
        output busy, done, array_enable, feed_rd_en, feed_addr,
               row_data_valid, col_weight_valid, result_capture,
               perf_busy_cycles, perf_stall_cycles
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Pass sequencer for a ROWS x COLS systolic MAC grid.
// One start runs one pass: K operand reads, skewed row/column valid strobes,
// a drain long enough for the last operand to cross the grid, then a single
// done/result_capture pulse. Everything past IDLE freezes while stall is high.
// Optional perf counters are built only when SYSTOLIC_SEQ_PERF_EN is defined;
// otherwise perf_busy_cycles/perf_stall_cycles are tied to zero.
module systolic_seq_ctrl #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int HOP_LAT = 2,
    parameter int RD_LAT  = 1,
    parameter int K_W     = 16
) (
    input logic               clk,
    input logic               rst,
    systolic_seq_ctrl_if.slave bus
);
    localparam int MAX_DIM   = (ROWS > COLS) ? ROWS : COLS;
    // Deepest tap is base_v (RD_LAT) plus the far-edge hop skew.
    localparam int DEPTH     = RD_LAT + HOP_LAT * (MAX_DIM - 1);
    // Last operand leaves the corner PE after crossing ROWS+COLS-1 hops.
    localparam int DRAIN_CYC = 1 + HOP_LAT * (ROWS + COLS - 1);
    localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [K_W-1:0]     step_q, step_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    // dly_q[i] = feed_rd_en delayed i+1 advancing cycles
    logic [DEPTH-1:0]   dly_q, dly_d;

    logic               adv;
    logic               busy;
    logic               done;
    logic               feed_rd_en;
    logic [K_W-1:0]     feed_addr;
    logic [ROWS-1:0]    row_v;
    logic [COLS-1:0]    col_v;

    // Next-state, counters, delay line and pass strobes
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        state_d    = state_q;
        step_d     = step_q;
        k_d        = k_q;
        drain_d    = drain_q;
        dly_d      = dly_q;
        adv        = (state_q != S_IDLE) && !bus.stall;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        feed_rd_en = 1'b0;
        feed_addr  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.cfg_k != '0) begin
                        k_d     = bus.cfg_k;
                        step_d  = '0;
                        dly_d   = '0;   // no valid leaks in from the previous pass
                        state_d = S_FEED;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FEED: begin
                feed_rd_en = adv;
                feed_addr  = step_q;
                if (adv) begin
                    step_d = step_q + K_W'(1);
                    if (step_q == k_q - K_W'(1)) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (adv) begin
                    if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        drain_d = drain_q + DRAIN_W'(1);
                    end
                end
            end
            S_DONE: begin
                // Single-cycle completion; stall cannot extend it.
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            dly_d[0] = feed_rd_en;
            for (int i = 1; i < DEPTH; i++) begin
                dly_d[i] = dly_q[i - 1];
            end
        end
    end

    // State, counters and skew delay line
    always_ff @(posedge clk) begin
        // NOTE: the skew line is a handful of flops, not a RAM, so clearing it on reset is cheap and keeps valids clean after an abort.
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            k_q     <= '0;
            drain_q <= '0;
            dly_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values computed above.
            state_q <= state_d;
            step_q  <= step_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            dly_q   <= dly_d;
        end
    end

    // Tap the delay line: each hop along the row/column adds HOP_LAT cycles
    always_comb begin
        row_v = '0;
        col_v = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_v[r] = dly_q[RD_LAT - 1 + r * HOP_LAT];
        end
        for (int c = 0; c < COLS; c++) begin
            col_v[c] = dly_q[RD_LAT - 1 + c * HOP_LAT];
        end
    end

    assign bus.busy             = busy;
    assign bus.done             = done;
    assign bus.result_capture   = done;
    assign bus.array_enable     = busy ? !bus.stall : 1'b1;
    assign bus.feed_rd_en       = feed_rd_en;
    assign bus.feed_addr        = feed_addr;
    assign bus.row_data_valid   = row_v;
    assign bus.col_weight_valid = col_v;

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating busy/stall cycle counters, restarted by each accepted start
    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if ((state_q == S_IDLE) && bus.start) begin
            perf_busy_d  = '0;
            perf_stall_d = '0;
        end else if (busy) begin
            if (perf_busy_q != '1) begin
                perf_busy_d = perf_busy_q + 32'd1;
            end
            if (bus.stall && (perf_stall_q != '1)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    // Perf counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign bus.perf_busy_cycles  = perf_busy_q;
    assign bus.perf_stall_cycles = perf_stall_q;
`else
    assign bus.perf_busy_cycles  = '0;
    assign bus.perf_stall_cycles = '0;
`endif

endmodule
